// File: rtl/ahb_lite_cordic_master_if.sv
// AHB-Lite bus between the CORDIC master and the accelerator's slave port.
// The master modport drives address/control/write data; the slave modport returns read data and response.
interface ahb_lite_cordic_master_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_cordic_master.sv
// AHB-Lite single-transfer master: writes an operand to the CORDIC block, polls status, reads the result.
// Optional poll timeout is enabled by defining CORDIC_MASTER_TIMEOUT_EN.
module ahb_lite_cordic_master #(
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  ahb_lite_cordic_master_if.master        ahb,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [31:0]                     cmd_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [31:0]                     res_data,
  output logic                            res_err,
  output logic                            busy,
  output logic [3:0]                      dbg_state
);

  // Handshakes: a command transfers on a cycle where cmd_valid && cmd_ready; a result transfers on
  // a cycle where res_valid && res_ready. Once valid is raised its data holds until that transfer.
  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_A, ST_WR_D, ST_GAP, ST_POLL_A, ST_POLL_D, ST_RD_A, ST_RD_D, ST_RESP
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [7:0] GAP_LOAD      = 8'(POLL_GAP);
  localparam state_t     AFTER_DATA    = (POLL_GAP == 0) ? ST_POLL_A : ST_GAP;

  state_t      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic        err_q, err_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        res_valid_q, res_valid_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        busy_q, busy_d;
  logic        timeout_hit;

`ifdef CORDIC_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_POLLS);
  logic [15:0] poll_cnt_q, poll_cnt_d;
  assign timeout_hit = ((poll_cnt_q + 16'd1) == TO_LIMIT);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_POLLS;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    gap_d      = gap_q;
    err_d      = err_q;
    hwdata_d   = hwdata_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
`ifdef CORDIC_MASTER_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          hwdata_d = cmd_data;
          err_d    = 1'b0;
          state_d  = ST_WR_A;
`ifdef CORDIC_MASTER_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      ST_WR_A:   if (ahb.HREADY) state_d = ST_WR_D;
      ST_POLL_A: if (ahb.HREADY) state_d = ST_POLL_D;
      ST_RD_A:   if (ahb.HREADY) state_d = ST_RD_D;
      ST_WR_D, ST_POLL_D, ST_RD_D: begin
        // err_q marks that the first ERROR cycle was seen; the second cycle ends the command.
        if (err_q) begin
          err_d      = 1'b0;
          res_err_d  = 1'b1;
          res_data_d = '0;
          state_d    = ST_RESP;
        end else if (ahb.HRESP) begin
          err_d = 1'b1;
        end else if (ahb.HREADY) begin
          if (state_q == ST_WR_D) begin
            gap_d   = GAP_LOAD;
            state_d = AFTER_DATA;
          end else if (state_q == ST_POLL_D) begin
`ifdef CORDIC_MASTER_TIMEOUT_EN
            poll_cnt_d = poll_cnt_q + 16'd1;
`endif
            if (ahb.HRDATA[0]) begin
              state_d = ST_RD_A;
            end else if (timeout_hit) begin
              res_err_d  = 1'b1;
              res_data_d = 32'hDEAD_0001;
              state_d    = ST_RESP;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = AFTER_DATA;
            end
          end else begin
            res_data_d = ahb.HRDATA;
            res_err_d  = 1'b0;
            state_d    = ST_RESP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q <= 8'd1) state_d = ST_POLL_A;
        else               gap_d   = gap_q - 8'd1;
      end
      ST_RESP: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Bus and port outputs are registered images of the state being entered.
    htrans_d = HTRANS_IDLE;
    haddr_d  = haddr_q;
    unique case (state_d)
      ST_WR_A:   begin htrans_d = HTRANS_NONSEQ; haddr_d = BASE_ADDR;          end
      ST_POLL_A: begin htrans_d = HTRANS_NONSEQ; haddr_d = BASE_ADDR + 32'h4;  end
      ST_RD_A:   begin htrans_d = HTRANS_NONSEQ; haddr_d = BASE_ADDR + 32'h8;  end
      default:   ;
    endcase
    hwrite_d    = (state_d == ST_WR_A);
    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      gap_q       <= '0;
      err_q       <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CORDIC_MASTER_TIMEOUT_EN
      poll_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
`ifdef CORDIC_MASTER_TIMEOUT_EN
      poll_cnt_q  <= poll_cnt_d;
`endif
    end
  end

  assign ahb.HADDR     = haddr_q;
  assign ahb.HTRANS    = htrans_q;
  assign ahb.HWRITE    = hwrite_q;
  assign ahb.HWDATA    = hwdata_q;
  assign ahb.HSIZE     = 3'b010;
  assign ahb.HBURST    = 3'b000;
  assign ahb.HPROT     = 4'b0011;
  assign ahb.HMASTLOCK = 1'b0;
  assign cmd_ready     = cmd_ready_q;
  assign res_valid     = res_valid_q;
  assign res_data      = res_data_q;
  assign res_err       = res_err_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ahb_lite_cordic_master.sv
// Directed bench for ahb_lite_cordic_master with a reactive AHB slave model and transfer scoreboard.
module tb_ahb_lite_cordic_master;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          GAP  = 4;
  localparam int          BASE_LAT = 7 + GAP;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        res_ready = 1'b0;
  logic        cmd_ready, res_valid, res_err, busy;
  logic [31:0] res_data;
  logic [3:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // slave knobs
  int          fail_polls = 0;
  int          wr_wait = 0;
  int          pa_wait = 0;
  int          rd_err = 0;
  int          polls_seen = 0;
  logic [31:0] rd_val = '0;
  int          poll_cyc[$];
  logic [64:0] exp_q[$];

  int hs, lat;

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  ahb_lite_cordic_master_if ahb ();

  ahb_lite_cordic_master #(
    .BASE_ADDR(BASE), .POLL_GAP(GAP), .TIMEOUT_POLLS(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(ahb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] rec(input logic w, input logic [31:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  // Slave: at posedge+1 retire the cycle just ended, then choose HREADY/HRESP/HRDATA for the new one.
  initial begin
    logic        dp, dp_wr;
    logic [31:0] dp_addr, a_p, wd_p;
    logic [1:0]  t_p;
    logic        w_p, rdy_p;
    logic [64:0] e;
    int          wait_left, err_phase;
    dp = 1'b0; dp_wr = 1'b0; dp_addr = '0; a_p = '0; wd_p = '0; t_p = '0; w_p = 1'b0; rdy_p = 1'b1;
    wait_left = 0; err_phase = 0;
    ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;
    forever begin
      @(posedge HCLK);
      #1;
      if (!HRESETn) begin
        dp = 1'b0; wait_left = 0; err_phase = 0; t_p = '0; rdy_p = 1'b1;
      end else begin
        if (dp && rdy_p) begin
          dp = 1'b0;
          if (exp_q.size() == 0) begin
            check("xfer_unexpected", dp_addr, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("xfer_write", {31'd0, dp_wr}, {31'd0, e[64]});
            check("xfer_addr", dp_addr, e[63:32]);
            if (dp_wr) check("xfer_wdata", wd_p, e[31:0]);
          end
        end
        if (t_p == 2'b10 && rdy_p) begin
          dp = 1'b1; dp_addr = a_p; dp_wr = w_p;
          wait_left = w_p ? wr_wait : 0;
          err_phase = (!w_p && a_p == BASE + 32'h8 && rd_err != 0) ? 1 : 0;
          if (a_p == BASE + 32'h4) poll_cyc.push_back(cyc);
        end
      end
      ahb.HREADY = 1'b1; ahb.HRESP = 1'b0; ahb.HRDATA = '0;
      if (dp) begin
        if (dp_wr && exp_q.size() > 0) check("hwdata_hold", ahb.HWDATA, exp_q[0][31:0]);
        if (err_phase == 1) begin
          ahb.HREADY = 1'b0; ahb.HRESP = 1'b1; err_phase = 2;
        end else if (err_phase == 2) begin
          ahb.HRESP = 1'b1; err_phase = 0;
        end else if (wait_left > 0) begin
          ahb.HREADY = 1'b0; wait_left--;
        end else if (dp_addr == BASE + 32'h4) begin
          ahb.HRDATA = (polls_seen >= fail_polls) ? 32'h1 : 32'h0;
          polls_seen++;
        end else begin
          ahb.HRDATA = rd_val;
        end
      end else if (HRESETn && ahb.HTRANS == 2'b10 && ahb.HADDR == BASE + 32'h4 && pa_wait > 0) begin
        ahb.HREADY = 1'b0; pa_wait--;
      end
      if (ahb.HREADY == 1'b0 && !dp) begin
        check("pa_hold_trans", {30'd0, ahb.HTRANS}, 32'd2);
        check("pa_hold_addr", ahb.HADDR, BASE + 32'h4);
      end
      t_p = ahb.HTRANS; a_p = ahb.HADDR; w_p = ahb.HWRITE; wd_p = ahb.HWDATA; rdy_p = ahb.HREADY;
    end
  end

  task automatic push_cmd(input logic [31:0] op, input int npolls);
    exp_q.push_back(rec(1'b1, BASE, op));
    for (int i = 0; i < npolls; i++) exp_q.push_back(rec(1'b0, BASE + 32'h4, 32'h0));
    exp_q.push_back(rec(1'b0, BASE + 32'h8, 32'h0));
  endtask

  task automatic send_cmd(input logic [31:0] op, output int hs_cyc);
    int n;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_data = op; n = 0;
    while (!cmd_ready && n < 20) begin @(negedge HCLK); n++; end
    check("cmd_accept_timeout", {31'd0, cmd_ready}, 32'd1);
    hs_cyc = cyc;
    @(negedge HCLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_res(input int hs_cyc, output int latency);
    int n;
    n = 0;
    while (!res_valid && n < 300) begin @(negedge HCLK); n++; end
    check("res_timeout", {31'd0, res_valid}, 32'd1);
    latency = cyc - hs_cyc;
  endtask

  task automatic take_res(input logic [31:0] exp_data, input logic exp_err);
    check("res_data", res_data, exp_data);
    check("res_err", {31'd0, res_err}, {31'd0, exp_err});
    check("busy_in_resp", {31'd0, busy}, 32'd1);
    res_ready = 1'b1;
    @(negedge HCLK);
    res_ready = 1'b0;
    check("res_valid_drop", {31'd0, res_valid}, 32'd0);
    check("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge HCLK);
    check("rst_htrans", {30'd0, ahb.HTRANS}, 32'd0);
    check("rst_haddr", ahb.HADDR, 32'd0);
    check("rst_hwrite", {31'd0, ahb.HWRITE}, 32'd0);
    check("rst_hwdata", ahb.HWDATA, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_err", {31'd0, res_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("const_hsize", {29'd0, ahb.HSIZE}, 32'd2);
    check("const_hprot", {28'd0, ahb.HPROT}, 32'd3);
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // zero-wait, result ready on first poll
    fail_polls = 0; polls_seen = 0; rd_val = 32'h0ABC_DEF0;
    push_cmd(32'h0000_1234, 1);
    send_cmd(32'h0000_1234, hs);
    wait_res(hs, lat);
    check("lat_zero_wait", lat, BASE_LAT);
    take_res(32'h0ABC_DEF0, 1'b0);

    // wait states: 3 in write data phase, 2 in poll address phase
    wr_wait = 3; pa_wait = 2; polls_seen = 0; rd_val = 32'h1357_9BDF;
    push_cmd(32'h5555_AAAA, 1);
    send_cmd(32'h5555_AAAA, hs);
    wait_res(hs, lat);
    check("lat_wait_states", lat, BASE_LAT + 5);
    take_res(32'h1357_9BDF, 1'b0);
    check("pa_wait_consumed", pa_wait, 0);

    // polling: not ready three times, then ready
    wr_wait = 0; fail_polls = 3; polls_seen = 0; rd_val = 32'hCAFE_F00D;
    poll_cyc.delete();
    push_cmd(32'h0000_0042, 4);
    send_cmd(32'h0000_0042, hs);
    wait_res(hs, lat);
    check("lat_polling", lat, BASE_LAT + 3 * (2 + GAP));
    check("poll_count", poll_cyc.size(), 4);
    for (int i = 1; i < 4; i++) check("poll_spacing", poll_cyc[i] - poll_cyc[i-1], 2 + GAP);
    take_res(32'hCAFE_F00D, 1'b0);

    // error response on the result read
    fail_polls = 0; polls_seen = 0; rd_err = 1; rd_val = 32'h1111_2222;
    push_cmd(32'h0000_0777, 1);
    send_cmd(32'h0000_0777, hs);
    wait_res(hs, lat);
    check("lat_error", lat, BASE_LAT + 1);
    check("err_htrans_idle", {30'd0, ahb.HTRANS}, 32'd0);
    take_res(32'h0000_0000, 1'b1);
    rd_err = 0;
    repeat (3) @(negedge HCLK);
    check("err_no_more_xfers", {31'd0, busy}, 32'd0);

    // backpressure on the result port
    polls_seen = 0; rd_val = 32'h8765_4321;
    push_cmd(32'h0000_0099, 1);
    send_cmd(32'h0000_0099, hs);
    wait_res(hs, lat);
    check("lat_backpressure", lat, BASE_LAT);
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      check("bp_res_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res_data", res_data, 32'h8765_4321);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    take_res(32'h8765_4321, 1'b0);

    // reset asserted during the first poll address phase
    fail_polls = 1000; polls_seen = 0;
    exp_q.push_back(rec(1'b1, BASE, 32'h0000_0055));
    exp_q.push_back(rec(1'b0, BASE + 32'h4, 32'h0));
    send_cmd(32'h0000_0055, hs);
    begin
      int n;
      n = 0;
      while (!(ahb.HTRANS == 2'b10 && ahb.HADDR == BASE + 32'h4) && n < 50) begin @(negedge HCLK); n++; end
      check("reach_poll_a", {30'd0, ahb.HTRANS}, 32'd2);
    end
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("rst_mid_htrans", {30'd0, ahb.HTRANS}, 32'd0);
    check("rst_mid_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    HRESETn = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge HCLK);
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_mid_stays_idle", {30'd0, ahb.HTRANS}, 32'd0);

`ifdef CORDIC_MASTER_TIMEOUT_EN
    // status never ready: abort after the eighth poll
    fail_polls = 1000; polls_seen = 0;
    poll_cyc.delete();
    exp_q.push_back(rec(1'b1, BASE, 32'h0000_0101));
    for (int i = 0; i < 8; i++) exp_q.push_back(rec(1'b0, BASE + 32'h4, 32'h0));
    send_cmd(32'h0000_0101, hs);
    wait_res(hs, lat);
    check("to_poll_count", poll_cyc.size(), 8);
    take_res(32'hDEAD_0001, 1'b1);
`endif

    repeat (2) @(negedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_lite_cordic_master.md
Name: ahb_lite_cordic_master

Overview:
AHB-Lite single-transfer master that drives the CORDIC accelerator's AHB-Lite slave port. It accepts one 32-bit operand per command over a valid/ready handshake and writes it to the accelerator. It then polls the accelerator's status register until a result is available, reads the result, and returns it over a valid/ready result port. It is used as the bus-side driver for the CORDIC subsystem in SoC integration and in block-level benches.

Parameters:
BASE_ADDR, 32'h4000_0000, accelerator base address; operand reg at +0x0, status reg at +0x4 (bit0 = result available), result reg at +0x8
POLL_GAP, 4, idle cycles between consecutive status polls (0..255)
TIMEOUT_POLLS, 1024, max status polls before abort (used only with the optional feature)

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, synchronous, active-low
HADDR  out  32  AHB address
HTRANS  out  2  AHB transfer type; IDLE=2'b00, NONSEQ=2'b10 only
HWRITE  out  1  AHB write
HSIZE  out  3  constant 3'b010 (word)
HBURST  out  3  constant 3'b000 (SINGLE)
HPROT  out  4  constant 4'b0011
HMASTLOCK  out  1  constant 0
HWDATA  out  32  AHB write data
HRDATA  in  32  AHB read data
HREADY  in  1  AHB transfer done / wait-state
HRESP  in  1  AHB error response
cmd_valid  in  1  operand valid
cmd_ready  out  1  master can accept an operand
cmd_data  in  32  operand
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  32  result word
res_err  out  1  result aborted (bus error or timeout); qualified by res_valid
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Clock and reset: one clock, HCLK. Reset is synchronous, active-low, on HRESETn.
- Outputs are registered. Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, cmd_ready=0 in reset cycle then 1, res_valid=0, res_data=0, res_err=0, busy=0.
- FSM states: IDLE, WR_A, WR_D, GAP, POLL_A, POLL_D, RD_A, RD_D, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid&cmd_ready, latch cmd_data and go to WR_A.
  - cmd_ready is 0 in every other state.
- Address phases (WR_A, POLL_A, RD_A):
  - Drive HTRANS=NONSEQ with HADDR = BASE+0x0 / +0x4 / +0x8 respectively. HWRITE=1 only in WR_A.
  - Hold all address-phase signals until HREADY=1, then drive HTRANS=IDLE and enter the matching data phase.
- Data phases (WR_D, POLL_D, RD_D):
  - WR_D: HWDATA = latched operand, held stable across HREADY=0 wait states.
  - POLL_D on HREADY=1: if HRDATA[0]=1, go to RD_A. Otherwise go to GAP, or straight to POLL_A when POLL_GAP=0.
  - RD_D on HREADY=1: capture HRDATA into res_data, set res_err=0, go to RESP.
  - WR_D on HREADY=1: go to GAP, or POLL_A when POLL_GAP=0.
- GAP: 8-bit down-counter loaded with POLL_GAP; go to POLL_A when it reaches 1.
- RESP: res_valid=1, and res_data/res_err hold stable until res_ready=1. On the handshake, res_valid goes to 0 and the FSM returns to IDLE.
- HRESP error handling:
  - HRESP=1 in any data phase: stay one extra cycle for the second response cycle (HTRANS stays IDLE), then go to RESP with res_err=1 and res_data=0.
  - Remaining steps of that command are skipped and no retry is attempted.
- Zero-wait-state timing, POLL_GAP=0, result ready on first poll: cmd handshake at cycle N; write address phase N+1; write data N+2; poll address N+3; poll data N+4; read address N+5; read data N+6; res_valid high at N+7.
- Reset asserted mid-transfer: next edge forces IDLE. HTRANS=IDLE from that edge; the in-flight data phase is abandoned and its result discarded.

Optional Feature:
- Macro: CORDIC_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit poll counter clears on command accept and increments per POLL_D completion.
  - When it reaches TIMEOUT_POLLS with HRDATA[0]=0, go to RESP with res_err=1 and res_data=32'hDEAD_0001.
- Undefined: the counter and compare logic are absent; polling continues indefinitely.

Test Plan:
- Zero-wait path: cmd_data=32'h0000_1234, status bit0=1 on first poll, result 32'h0ABC_DEF0 -> bus shows WR @BASE+0 data 0x1234, RD @BASE+4, RD @BASE+8; res_valid at N+7 with res_data=0x0ABC_DEF0, res_err=0.
- Wait states: HREADY=0 for 3 cycles in WR_D and 2 cycles in POLL_A -> HWDATA, HADDR and HTRANS held stable throughout; result is unchanged and 5 cycles later.
- Polling: status bit0=0 for 3 polls then 1, with POLL_GAP=4 -> exactly 4 polls to BASE+4, each spaced 4 IDLE cycles, then one read of BASE+8.
- Error: HRESP=1 (two cycles) in the RD_D phase -> no further transfers; res_valid with res_err=1, res_data=0.
- Backpressure and reset: hold res_ready=0 for 10 cycles -> res_valid and res_data stable, cmd_ready=0. A later HRESETn=0 during POLL_A -> next cycle HTRANS=IDLE, res_valid=0, busy=0.
- With CORDIC_MASTER_TIMEOUT_EN and TIMEOUT_POLLS=8, status always 0 -> exactly 8 polls, then res_err=1, res_data=32'hDEAD_0001.
